// File: rtl/mips16_pkg.sv
// Shared constants for the 16-bit MIPS core: datapath widths, run-state
// encoding and host command codes.
package mips16_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  // Run-state encoding is fixed by the host-visible state port.
  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_STOP = 2'b01,
    CMD_STEP = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_e;

endpackage

// File: rtl/mips16_run_ctrl_if.sv
// Host/core-facing bundle of the run controller; master = core and host side,
// slave = the controller itself.
interface mips16_run_ctrl_if;
  import mips16_pkg::*;

  logic              cmd_valid;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] pc;
  logic              mem_req;
  logic              mem_ready;
  logic              bp_en;
  logic [ADDR_W-1:0] bp_addr;

  logic              cpu_en;
  logic [1:0]        state;
  logic              bp_hit;
  logic              mem_err;
  logic [DATA_W-1:0] retired;

  modport master (
    output cmd_valid, cmd, pc, mem_req, mem_ready, bp_en, bp_addr,
    input  cpu_en, state, bp_hit, mem_err, retired
  );

  modport slave (
    input  cmd_valid, cmd, pc, mem_req, mem_ready, bp_en, bp_addr,
    output cpu_en, state, bp_hit, mem_err, retired
  );

endinterface

// File: rtl/mips16_stall_timer.sv
// Counts consecutive data-memory stall cycles and flags the cycle in which the
// count reaches MEM_TIMEOUT while the stall is still present.
module mips16_stall_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  localparam logic [7:0] LP_LIMIT = 8'(MEM_TIMEOUT);

  logic [7:0] r_wait_cnt;

  assign o_timeout = i_inc && (r_wait_cnt == LP_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (i_clr) begin
      r_wait_cnt <= 8'd0;
    end else if (i_inc) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mips16_run_ctrl.sv
// Execution controller: commit enable, HALT/RUN/STEP sequencing, memory stall
// timeout and retired-instruction count. Breakpoints need MIPS16_BREAKPOINT_EN.
module mips16_run_ctrl
  import mips16_pkg::*;
#(
  parameter bit          RESET_RUN   = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  mips16_run_ctrl_if.slave bus
);

  localparam logic [1:0] LP_RST_STATE = RESET_RUN ? ST_RUN : ST_HALT;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [DATA_W-1:0] r_retired;
  logic              r_mem_err;
  cmd_e              w_cmd;
  logic              w_exec;
  logic              w_stall;
  logic              w_brk;
  logic              w_cpu_en;
  logic              w_clr;
  logic              w_timeout;
  logic              w_accept;
  logic              w_set_bp;
  logic              w_set_err;
  logic              w_halt_entry;

  assign w_cmd    = cmd_e'(bus.cmd);
  assign w_exec   = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_stall  = bus.mem_req && !bus.mem_ready;
  assign w_cpu_en = w_exec && !w_stall && !w_brk;
  assign w_clr    = bus.cmd_valid && (w_cmd == CMD_CLR);

`ifdef MIPS16_BREAKPOINT_EN
  logic r_skip;
  logic r_bp_hit;

  // skip lets a resumed core retire the instruction sitting on the breakpoint.
  assign w_brk = bus.bp_en && (bus.pc == bus.bp_addr) && !r_skip && (r_state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip   <= 1'b0;
      r_bp_hit <= 1'b0;
    end else begin
      if (w_accept)      r_skip <= 1'b1;
      else if (w_cpu_en) r_skip <= 1'b0;

      if (w_set_bp)                r_bp_hit <= 1'b1;
      else if (w_accept || w_clr)  r_bp_hit <= 1'b0;
    end
  end

  assign bus.bp_hit = r_bp_hit;
`else
  logic w_unused;

  assign w_brk      = 1'b0;
  assign bus.bp_hit = 1'b0;
  assign w_unused   = &{1'b0, bus.bp_en, bus.bp_addr, w_set_bp};
`endif

  // Commands outrank internally caused halts; a commit in the same cycle
  // still happens because cpu_en does not look at the command port.
  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_set_bp    = 1'b0;
    w_set_err   = 1'b0;
    if (bus.cmd_valid && (w_cmd == CMD_STOP)) begin
      w_state_nxt = ST_HALT;
    end else if (bus.cmd_valid && (w_cmd == CMD_RUN) && (r_state != ST_RUN)) begin
      w_state_nxt = ST_RUN;
      w_accept    = 1'b1;
    end else if (bus.cmd_valid && (w_cmd == CMD_STEP) && (r_state == ST_HALT)) begin
      w_state_nxt = ST_STEP;
      w_accept    = 1'b1;
    end else if (bus.cmd_valid && (w_cmd == CMD_STEP) && (r_state == ST_RUN)) begin
      w_state_nxt = ST_STEP;
    end else if (w_brk) begin
      w_state_nxt = ST_HALT;
      w_set_bp    = 1'b1;
    end else if ((r_state == ST_STEP) && w_cpu_en) begin
      w_state_nxt = ST_HALT;
    end else if (w_timeout) begin
      w_state_nxt = ST_HALT;
      w_set_err   = 1'b1;
    end
  end

  assign w_halt_entry = (w_state_nxt == ST_HALT) && (r_state != ST_HALT);

  mips16_stall_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_stall_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_cpu_en || w_halt_entry),
    .i_inc     (w_exec && w_stall),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LP_RST_STATE;
      r_retired <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_clr)         r_retired <= '0;
      else if (w_cpu_en) r_retired <= r_retired + 1'b1;

      if (w_set_err)               r_mem_err <= 1'b1;
      else if (w_accept || w_clr)  r_mem_err <= 1'b0;
    end
  end

  assign bus.cpu_en  = w_cpu_en;
  assign bus.state   = r_state;
  assign bus.mem_err = r_mem_err;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_mips16_run_ctrl.sv
// Randomised and directed checks of mips16_run_ctrl against a cycle-level
// behavioural model; the bench also plays the core (PC advances on cpu_en).
module tb_mips16_run_ctrl;

  localparam int T_MEM = 4;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  localparam logic [1:0] C_RUN  = 2'd0;
  localparam logic [1:0] C_STOP = 2'd1;
  localparam logic [1:0] C_STEP = 2'd2;
  localparam logic [1:0] C_CLR  = 2'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        t_cv, t_mq, t_mr, t_be;
  logic [1:0]  t_cmd;
  logic [15:0] t_ba;
  logic [15:0] core_pc;
  logic [15:0] loop_top;

  mips16_run_ctrl_if bus ();

  assign bus.cmd_valid = t_cv;
  assign bus.cmd       = t_cmd;
  assign bus.pc        = core_pc;
  assign bus.mem_req   = t_mq;
  assign bus.mem_ready = t_mr;
  assign bus.bp_en     = t_be;
  assign bus.bp_addr   = t_ba;

  mips16_run_ctrl #(
    .RESET_RUN   (1'b0),
    .MEM_TIMEOUT (T_MEM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int m_state;
  int m_retired;
  bit m_bp, m_err, m_skip;
  int m_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_brk();
`ifdef MIPS16_BREAKPOINT_EN
    return t_be && (core_pc == t_ba) && !m_skip && (m_state == M_RUN);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_en();
    return (m_state != M_HALT) && !(t_mq && !t_mr) && !exp_brk();
  endfunction

  task automatic model_reset();
    m_state = M_HALT; m_retired = 0; m_bp = 0; m_err = 0; m_skip = 0; m_wait = 0;
  endtask

  task automatic model_clock(input bit en);
    bit stall  = t_mq && !t_mr;
    bit ex     = (m_state != M_HALT);
    bit brk    = exp_brk();
    bit tmo    = ex && stall && (m_wait == T_MEM);
    bit is_clr = t_cv && (t_cmd == C_CLR);
    bit acc = 0, sbp = 0, serr = 0;
    int ns = m_state;
    if (t_cv && t_cmd == C_STOP) ns = M_HALT;
    else if (t_cv && t_cmd == C_RUN && m_state != M_RUN) begin ns = M_RUN; acc = 1; end
    else if (t_cv && t_cmd == C_STEP && m_state == M_HALT) begin ns = M_STEP; acc = 1; end
    else if (t_cv && t_cmd == C_STEP && m_state == M_RUN) ns = M_STEP;
    else if (brk) begin ns = M_HALT; sbp = 1; end
    else if (m_state == M_STEP && en) ns = M_HALT;
    else if (tmo) begin ns = M_HALT; serr = 1; end
    if (acc || is_clr) begin m_bp = 0; m_err = 0; end
    if (sbp)  m_bp = 1;
    if (serr) m_err = 1;
    if (is_clr)  m_retired = 0;
    else if (en) m_retired = (m_retired + 1) % 65536;
    if (acc)     m_skip = 1;
    else if (en) m_skip = 0;
    if (en || (ns == M_HALT && m_state != M_HALT)) m_wait = 0;
    else if (ex && stall) m_wait = m_wait + 1;
    m_state = ns;
  endtask

  // One clock: drive at the falling edge, compare 1 time unit later, update
  // the model and the core PC at the rising edge, return at the next falling edge.
  task automatic cycle(input bit cv, input logic [1:0] c, input bit mq, input bit mr);
    bit en, dut_en;
    t_cv = cv; t_cmd = c; t_mq = mq; t_mr = mr;
    #1;
    en     = exp_en();
    dut_en = bus.cpu_en;
    check("cpu_en",  {31'd0, bus.cpu_en}, {31'd0, en});
    check("state",   {30'd0, bus.state},  m_state);
    check("bp_hit",  {31'd0, bus.bp_hit}, {31'd0, m_bp});
    check("mem_err", {31'd0, bus.mem_err}, {31'd0, m_err});
    check("retired", {16'd0, bus.retired}, m_retired);
    @(posedge clk);
    model_clock(en);
    if (dut_en) core_pc = (core_pc >= loop_top) ? 16'd0 : core_pc + 16'd2;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    t_cv = 0; t_cmd = C_RUN; t_mq = 0; t_mr = 0;
    #1;
    model_reset();
    check("rst_state",   {30'd0, bus.state}, M_HALT);
    check("rst_cpu_en",  {31'd0, bus.cpu_en}, 0);
    check("rst_retired", {16'd0, bus.retired}, 0);
    check("rst_bp_hit",  {31'd0, bus.bp_hit}, 0);
    check("rst_mem_err", {31'd0, bus.mem_err}, 0);
    @(negedge clk);
    t_cv = 1; t_cmd = C_RUN;
    #1;
    check("rst_hold_cpu_en", {31'd0, bus.cpu_en}, 0);
    @(negedge clk);
    t_cv = 0;
    core_pc = 16'd0;
    rst_n = 1'b1;
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (m_state != M_HALT && n < budget) begin
      cycle(0, C_RUN, 0, 0);
      n++;
    end
    if (m_state != M_HALT) check("halt_budget", {30'd0, bus.state}, M_HALT);
  endtask

  initial begin
    int lvl_q, lvl_r, r0;
    rst_n = 1'b0;
    t_cv = 0; t_cmd = C_RUN; t_mq = 0; t_mr = 0; t_be = 0; t_ba = 16'd0;
    core_pc = 16'd0; loop_top = 16'hFFFF;
    model_reset();
    @(negedge clk);
    do_reset();

    // Three single steps from HALT
    for (int i = 0; i < 3; i++) begin
      cycle(1, C_STEP, 0, 0);
      cycle(0, C_RUN, 0, 0);
      cycle(0, C_RUN, 0, 0);
    end
    check("step_retired", {16'd0, bus.retired}, 3);
    check("step_state",   {30'd0, bus.state}, M_HALT);

    // Three-cycle stall then ready; then STOP coincident with a commit
    cycle(1, C_RUN, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, C_RUN, 1, 0);
    cycle(0, C_RUN, 1, 1);
    check("stall_mem_err", {31'd0, bus.mem_err}, 0);
    check("stall_retired", {16'd0, bus.retired}, 4);
    cycle(1, C_STOP, 0, 0);
    check("stop_retired", {16'd0, bus.retired}, 5);
    check("stop_cpu_en",  {31'd0, bus.cpu_en}, 0);
    cycle(0, C_RUN, 0, 0);

    // Memory timeout: HALT MEM_TIMEOUT+1 cycles after the stall begins
    cycle(1, C_RUN, 0, 0);
    for (int i = 0; i < T_MEM + 1; i++) cycle(0, C_RUN, 1, 0);
    check("tmo_state",   {30'd0, bus.state}, M_HALT);
    check("tmo_mem_err", {31'd0, bus.mem_err}, 1);
    check("tmo_retired", {16'd0, bus.retired}, 5);
    cycle(1, C_RUN, 0, 0);
    check("tmo_clear", {31'd0, bus.mem_err}, 0);
    cycle(1, C_STOP, 0, 0);

    // Reset in the middle of a stall discards the partial wait count
    cycle(1, C_RUN, 0, 0);
    cycle(0, C_RUN, 1, 0);
    cycle(0, C_RUN, 1, 0);
    do_reset();
    cycle(1, C_RUN, 0, 0);
    for (int i = 0; i < T_MEM; i++) cycle(0, C_RUN, 1, 0);
    check("rst_stall_run", {30'd0, bus.state}, M_RUN);
    cycle(0, C_RUN, 1, 0);
    check("rst_stall_halt", {30'd0, bus.state}, M_HALT);

`ifdef MIPS16_BREAKPOINT_EN
    // Breakpoint at 0x0008 on a loop 0x0000..0x000C
    cycle(1, C_CLR, 0, 0);
    core_pc = 16'd0; loop_top = 16'h000C; t_be = 1; t_ba = 16'h0008;
    cycle(1, C_RUN, 0, 0);
    run_until_halt(20);
    check("bp_pc",      {16'd0, core_pc}, 32'h8);
    check("bp_flag",    {31'd0, bus.bp_hit}, 1);
    check("bp_retired", {16'd0, bus.retired}, 4);
    cycle(1, C_RUN, 0, 0);
    run_until_halt(40);
    check("bp2_pc",      {16'd0, core_pc}, 32'h8);
    check("bp2_retired", {16'd0, bus.retired}, 11);
    t_be = 0; loop_top = 16'hFFFF;
`endif

    // Counter wrap, then CLR coincident with a commit
    cycle(1, C_CLR, 0, 0);
    cycle(1, C_RUN, 0, 0);
    for (int n = 0; n < 70000 && m_retired != 16'hFFFD; n++) cycle(0, C_RUN, 0, 0);
    cycle(1, C_STOP, 0, 0);
    check("wrap_pre", {16'd0, bus.retired}, 32'hFFFE);
    cycle(1, C_RUN, 0, 0);
    cycle(0, C_RUN, 0, 0);
    cycle(0, C_RUN, 0, 0);
    cycle(1, C_STOP, 0, 0);
    check("wrap_post", {16'd0, bus.retired}, 32'h0001);
    cycle(1, C_RUN, 0, 0);
    cycle(0, C_RUN, 0, 0);
    cycle(1, C_CLR, 0, 0);
    check("clr_commit", {16'd0, bus.retired}, 0);
    check("clr_state",  {30'd0, bus.state}, M_RUN);

    // Randomised traffic in blocks with varying memory and command pressure
    loop_top = 16'h000E;
    for (int b = 0; b < 15; b++) begin
      lvl_q = $urandom_range(0, 100);
      lvl_r = $urandom_range(0, 95);
      t_be  = $urandom_range(0, 1);
      t_ba  = 16'($urandom_range(0, 7) * 2);
      for (int i = 0; i < 200; i++) begin
        r0 = $urandom_range(0, 99);
        cycle(r0 < 12, 2'($urandom_range(0, 3)),
              $urandom_range(0, 99) < lvl_q, $urandom_range(0, 99) >= lvl_r);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
